// File: rtl/life_pkg.sv
// Shared types and default sizes for the life tile datapath: FSM state enum, tile geometry, latency counter width.
package life_pkg;
    localparam int N_TILES_DEF = 4;
    localparam int TILE_W_DEF  = 16;
    localparam int SEL_W_DEF   = 2;
    localparam int CNT_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DONE
    } state_t;
endpackage

// File: rtl/rd_lat_counter.sv
// Loadable down-counter that times the Block_Mem read latency; zero flags that the read data is due.
module rd_lat_counter import life_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/tile_readback.sv
// Reads N_TILES tile words out of Block_Mem and streams them to the life array over a valid/ready handshake.
// Defining READBACK_CSUM_EN adds the checksum port: XOR of every tile transferred in the most recent pass.
module tile_readback import life_pkg::*; #(
    parameter int N_TILES = N_TILES_DEF,
    parameter int TILE_W  = TILE_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  mem_sel,
    output logic              mem_rd_en,
    input  logic [TILE_W-1:0] mem_data,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [TILE_W-1:0] tile_data,
    output logic [SEL_W-1:0]  tile_pos
`ifdef READBACK_CSUM_EN
    ,
    output logic [TILE_W-1:0] checksum
`endif
);
    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] idx;
    logic             last_tile;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             capture;
    logic             xfer;

    assign last_tile  = (idx == SEL_W'(N_TILES - 1));
    assign mem_sel    = idx;
    assign busy       = (state == REQ) || (state == WAIT) || (state == HOLD);
    assign done       = (state == DONE);
    assign tile_valid = (state == HOLD);

    rd_lat_counter u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CNT_W'(RD_LAT)),
        .zero     (cnt_zero)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                cnt_load   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (tile_ready) begin
                    xfer       = 1'b1;
                    next_state = last_tile ? DONE : REQ;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The read strobe is registered, so Block_Mem sees it in the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            mem_rd_en <= 1'b0;
            tile_data <= '0;
            tile_pos  <= '0;
        end else begin
            state     <= next_state;
            mem_rd_en <= cnt_load;
            if (capture) begin
                tile_data <= mem_data;
                tile_pos  <= idx;
            end
            if (xfer) begin
                idx <= last_tile ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef READBACK_CSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum ^ tile_data;
        end
    end
`endif

    logic unused_accept;
    assign unused_accept = accept;
endmodule

// File: tb/tb_tile_readback.sv
// Directed bench for tile_readback: one DUT at RD_LAT=1 (main scenarios) and one at RD_LAT=3 (latency/early garbage).
module tb_tile_readback;
    logic        clk;
    logic        reset;

    logic        start_a, busy_a, done_a, rd_a, valid_a, ready_a;
    logic [1:0]  sel_a, pos_a;
    logic [15:0] mdata_a, data_a, csum_a;

    logic        start_b, busy_b, done_b, rd_b, valid_b, ready_b;
    logic [1:0]  sel_b, pos_b;
    logic [15:0] mdata_b, data_b, csum_b;

    logic [15:0] mem [4];
    logic [2:0]  pen_b;
    logic [1:0]  psel_b [3];

    int checks;
    int errors;

    int          r_nx, r_ndone, r_first_valid, r_first_rd, r_done_cyc, r_last_xfer;
    int          r_stall_cycles, r_stall_rd, r_stall_bad;
    logic [15:0] r_csum0;
    logic [15:0] r_data [8];
    logic [1:0]  r_pos  [8];

    tile_readback #(.N_TILES(4), .TILE_W(16), .SEL_W(2), .RD_LAT(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .busy       (busy_a),
        .done       (done_a),
        .mem_sel    (sel_a),
        .mem_rd_en  (rd_a),
        .mem_data   (mdata_a),
        .tile_valid (valid_a),
        .tile_ready (ready_a),
        .tile_data  (data_a),
        .tile_pos   (pos_a)
`ifdef READBACK_CSUM_EN
        ,
        .checksum   (csum_a)
`endif
    );

    tile_readback #(.N_TILES(4), .TILE_W(16), .SEL_W(2), .RD_LAT(3)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .busy       (busy_b),
        .done       (done_b),
        .mem_sel    (sel_b),
        .mem_rd_en  (rd_b),
        .mem_data   (mdata_b),
        .tile_valid (valid_b),
        .tile_ready (ready_b),
        .tile_data  (data_b),
        .tile_pos   (pos_b)
`ifdef READBACK_CSUM_EN
        ,
        .checksum   (csum_b)
`endif
    );

`ifndef READBACK_CSUM_EN
    assign csum_a = 16'h0000;
    assign csum_b = 16'h0000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data is valid for exactly one cycle, RD_LAT cycles after the strobe is sampled.
    always @(posedge clk) mdata_a <= rd_a ? mem[sel_a] : 16'hDEAD;

    always @(posedge clk) begin
        pen_b     <= {pen_b[1:0], rd_b};
        psel_b[0] <= sel_b;
        psel_b[1] <= psel_b[0];
        psel_b[2] <= psel_b[1];
    end
    assign mdata_b = pen_b[2] ? mem[psel_b[2]] : (pen_b[1] ? 16'hBAD1 : 16'hDEAD);

    task automatic run_pass_a(input int stall_tile, input int stall_len, input bit poke);
        int          stalled;
        logic [15:0] hold_d;
        logic [1:0]  hold_p;
        r_nx = 0; r_ndone = 0; r_first_valid = -1; r_first_rd = -1; r_done_cyc = -100;
        r_last_xfer = -100; r_stall_cycles = 0; r_stall_rd = 0; r_stall_bad = 0;
        stalled = 0; hold_d = '0; hold_p = '0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        r_csum0 = csum_a;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (r_ndone > 0 && cyc >= r_done_cyc + 3) break;
            if (valid_a && r_first_valid < 0) r_first_valid = cyc;
            if (rd_a && r_first_rd < 0) r_first_rd = cyc;
            if (done_a) begin
                r_ndone++;
                r_done_cyc = cyc;
            end
            start_a = poke && (valid_a || done_a);
            if (r_nx == stall_tile && stalled > 0 && stalled < stall_len && !valid_a) r_stall_bad++;
            if (valid_a && r_nx == stall_tile && stalled < stall_len) begin
                if (stalled > 0 && (data_a !== hold_d || pos_a !== hold_p)) r_stall_bad++;
                hold_d = data_a;
                hold_p = pos_a;
                if (rd_a) r_stall_rd++;
                stalled++;
                r_stall_cycles = stalled;
                ready_a = 1'b0;
            end else begin
                ready_a = 1'b1;
            end
            if (valid_a && ready_a) begin
                if (r_nx < 8) begin
                    r_data[r_nx] = data_a;
                    r_pos[r_nx]  = pos_a;
                end
                r_nx++;
                r_last_xfer = cyc;
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
        checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
        checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel_a); end
        checks++; if (data_a !== 16'h0000 || pos_a !== 2'd0) begin
            errors++; $display("FAIL reset_data got %h/%0d want 0000/0", data_a, pos_a);
        end
        checks++; if (csum_a !== 16'h0000) begin errors++; $display("FAIL reset_csum got %h want 0000", csum_a); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_pass_a(-1, 0, 1'b0);
        checks++; if (r_first_rd !== 1) begin errors++; $display("FAIL basic_rd_latency got %0d want 1", r_first_rd); end
        checks++; if (r_first_valid !== 3) begin errors++; $display("FAIL basic_valid_latency got %0d want 3", r_first_valid); end
        checks++; if (r_nx !== 4) begin errors++; $display("FAIL basic_xfers got %0d want 4", r_nx); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r_pos[i] !== 2'(i) || r_data[i] !== mem[i]) begin
                errors++; $display("FAIL basic_tile%0d got %0d:%h want %0d:%h", i, r_pos[i], r_data[i], i, mem[i]);
            end
        end
        checks++; if (r_ndone !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", r_ndone); end
        checks++; if (r_done_cyc !== r_last_xfer + 1) begin
            errors++; $display("FAIL basic_done_timing got %0d want %0d", r_done_cyc, r_last_xfer + 1);
        end
        checks++; if (sel_a !== 2'd0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after got sel=%0d busy=%b want 0/0", sel_a, busy_a);
        end
    endtask

    task automatic test_backpressure();
        run_pass_a(1, 10, 1'b0);
        checks++; if (r_stall_cycles !== 10) begin errors++; $display("FAIL bp_stall_len got %0d want 10", r_stall_cycles); end
        checks++; if (r_stall_bad !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", r_stall_bad); end
        checks++; if (r_stall_rd !== 0) begin errors++; $display("FAIL bp_no_read got %0d strobes want 0", r_stall_rd); end
        checks++; if (r_nx !== 4) begin errors++; $display("FAIL bp_xfers got %0d want 4", r_nx); end
        checks++; if (r_pos[1] !== 2'd1 || r_data[1] !== 16'h8000) begin
            errors++; $display("FAIL bp_tile1 got %0d:%h want 1:8000", r_pos[1], r_data[1]);
        end
        checks++; if (r_pos[3] !== 2'd3 || r_data[3] !== 16'h1234) begin
            errors++; $display("FAIL bp_tile3 got %0d:%h want 3:1234", r_pos[3], r_data[3]);
        end
        checks++; if (r_ndone !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", r_ndone); end
    endtask

    task automatic test_start_ignored();
        run_pass_a(-1, 0, 1'b1);
        checks++; if (r_nx !== 4) begin errors++; $display("FAIL ign_xfers got %0d want 4", r_nx); end
        checks++; if (r_ndone !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", r_ndone); end
        checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++; $display("FAIL ign_idle_after got busy=%b valid=%b want 0/0", busy_a, valid_a);
        end
    endtask

    task automatic test_reset_midpass();
        bit found;
        int ndone;
        found = 1'b0;
        ndone = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_a && sel_a == 2'd2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_tile2 got %b want 1", found); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0 || rd_a !== 1'b0 || done_a !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl got busy=%b valid=%b rd=%b done=%b want 0", busy_a, valid_a, rd_a, done_a);
        end
        checks++; if (sel_a !== 2'd0 || pos_a !== 2'd0 || data_a !== 16'h0000) begin
            errors++; $display("FAIL mid_regs got sel=%0d pos=%0d data=%h want 0", sel_a, pos_a, data_a);
        end
        for (int i = 0; i < 6; i++) begin
            if (done_a || busy_a) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", ndone); end
        run_pass_a(-1, 0, 1'b0);
        checks++; if (r_nx !== 4 || r_ndone !== 1) begin
            errors++; $display("FAIL mid_repass got %0d xfers %0d done want 4/1", r_nx, r_ndone);
        end
        checks++; if (r_pos[0] !== 2'd0 || r_data[0] !== 16'h0001) begin
            errors++; $display("FAIL mid_repass_tile0 got %0d:%h want 0:0001", r_pos[0], r_data[0]);
        end
    endtask

    task automatic test_rd_lat3();
        int          first_v, nx, ndone;
        logic [15:0] d [4];
        logic [1:0]  p [4];
        first_v = -1; nx = 0; ndone = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = '0;
            p[i] = '0;
        end
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (valid_b && first_v < 0) first_v = cyc;
            if (done_b) ndone++;
            if (valid_b && ready_b) begin
                if (nx < 4) begin
                    d[nx] = data_b;
                    p[nx] = pos_b;
                end
                nx++;
            end
            @(posedge clk); #1;
        end
        checks++; if (first_v !== 5) begin errors++; $display("FAIL lat3_valid_latency got %0d want 5", first_v); end
        checks++; if (nx !== 4 || ndone !== 1) begin
            errors++; $display("FAIL lat3_counts got %0d xfers %0d done want 4/1", nx, ndone);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (p[i] !== 2'(i) || d[i] !== mem[i]) begin
                errors++; $display("FAIL lat3_tile%0d got %0d:%h want %0d:%h", i, p[i], d[i], i, mem[i]);
            end
        end
        checks++; if (busy_b !== 1'b0 || sel_b !== 2'd0) begin
            errors++; $display("FAIL lat3_idle_after got busy=%b sel=%0d want 0/0", busy_b, sel_b);
        end
    endtask

`ifdef READBACK_CSUM_EN
    task automatic test_checksum();
        checks++; if (csum_a !== 16'h62C5) begin errors++; $display("FAIL csum_after_pass got %h want 62c5", csum_a); end
        checks++; if (csum_b !== 16'h62C5) begin errors++; $display("FAIL csum_lat3 got %h want 62c5", csum_b); end
        run_pass_a(-1, 0, 1'b0);
        checks++; if (r_csum0 !== 16'h0000) begin errors++; $display("FAIL csum_clear_on_start got %h want 0000", r_csum0); end
        checks++; if (csum_a !== 16'h62C5) begin errors++; $display("FAIL csum_repass got %h want 62c5", csum_a); end
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        mem[0]  = 16'h0001;
        mem[1]  = 16'h8000;
        mem[2]  = 16'hF0F0;
        mem[3]  = 16'h1234;
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_reset_midpass();
        test_rd_lat3();
`ifdef READBACK_CSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
